// File: rtl/nr_raster_framer.sv
// nr_raster_framer: buffers a bursty valid/ready pixel stream and replays it as a fixed-raster {vsync,hsync,den,rgb} bus.
// Optional colour-bar test pattern is compiled in by defining NR_FRAMER_TPG_EN (adds the tpg_sel input).
module nr_raster_framer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int H_BLANK    = 8,
  parameter int HSYNC_W    = 4,
  parameter int V_GAP      = 160,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [23:0]                 s_data,
  input  logic                        s_sof,
`ifdef NR_FRAMER_TPG_EN
  input  logic                        tpg_sel,
`endif
  output logic [26:0]                 dpo,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun,
  output logic                        sof_err,
  output logic                        frame_done
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int CMAX = (H_ACTIVE > V_GAP) ? ((H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK)
                                           : ((V_GAP > H_BLANK) ? V_GAP : H_BLANK);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int VW   = $clog2(V_ACTIVE + 1);

  typedef enum logic [2:0] {IDLE, SEEK, WAIT, ACTIVE, HBLANK, VGAP} state_t;

  logic [24:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level, w_level_nxt;
  logic          r_s_ready, w_ready_nxt;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_h_cnt, w_h_nxt;
  logic [VW-1:0] r_v_cnt, w_v_nxt;
  logic          r_tpg, w_tpg_nxt, w_tpg_sel;
  logic [26:0]   r_dpo, w_dpo_nxt;
  logic          r_frame_done, w_fd_nxt;
  logic          r_underrun, w_ur_set;
  logic          r_sof_err, w_se_set;
  logic          w_push, w_pop, w_empty, w_wait_ok, w_go;
  logic [24:0]   w_head;
  logic [23:0]   w_bar_rgb;

  assign w_push    = s_valid && r_s_ready;
  assign w_empty   = (r_level == '0);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_wait_ok = (r_level >= LW'(H_ACTIVE));
  assign w_go      = r_tpg || w_wait_ok;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {s_sof, s_data};
  end

  // A full line already buffered lets HBLANK hand straight to ACTIVE, so the gap is exactly H_BLANK.
  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h_cnt;
    w_v_nxt     = r_v_cnt;
    w_tpg_nxt   = r_tpg;
    w_pop       = 1'b0;
    w_dpo_nxt   = '0;
    w_fd_nxt    = 1'b0;
    w_ur_set    = 1'b0;
    w_se_set    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt = SEEK;
          w_tpg_nxt   = w_tpg_sel;
        end
      end
      SEEK: begin
        if (r_tpg) w_state_nxt = WAIT;
        else if (!w_empty) begin
          if (w_head[24]) w_state_nxt = WAIT;
          else            w_pop       = 1'b1;
        end
      end
      WAIT: begin
        if (w_go) w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        w_dpo_nxt[24] = 1'b1;
        if (r_tpg) w_dpo_nxt[23:0] = w_bar_rgb;
        else if (w_empty) w_ur_set = 1'b1;
        else begin
          w_pop           = 1'b1;
          w_dpo_nxt[23:0] = w_head[23:0];
          w_se_set        = w_head[24] && ((r_h_cnt != '0) || (r_v_cnt != '0));
        end
        if (r_h_cnt == CW'(H_ACTIVE - 1)) begin
          w_h_nxt = '0;
          if (r_v_cnt == VW'(V_ACTIVE - 1)) begin
            w_v_nxt     = '0;
            w_state_nxt = VGAP;
          end else begin
            w_v_nxt     = r_v_cnt + 1'b1;
            w_state_nxt = HBLANK;
          end
        end else begin
          w_h_nxt = r_h_cnt + 1'b1;
        end
      end
      HBLANK: begin
        w_dpo_nxt[25] = (r_h_cnt < CW'(HSYNC_W));
        if (r_h_cnt == CW'(H_BLANK - 1)) begin
          w_h_nxt     = '0;
          w_state_nxt = w_go ? ACTIVE : WAIT;
        end else begin
          w_h_nxt = r_h_cnt + 1'b1;
        end
      end
      VGAP: begin
        w_dpo_nxt[26] = 1'b1;
        if (r_h_cnt == CW'(V_GAP - 1)) begin
          w_h_nxt     = '0;
          w_fd_nxt    = 1'b1;
          w_tpg_nxt   = w_tpg_sel;
          w_state_nxt = enable ? SEEK : IDLE;
        end else begin
          w_h_nxt = r_h_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + 1'b1;
    else if (!w_push && w_pop) w_level_nxt = r_level - 1'b1;
    w_ready_nxt = (w_level_nxt != LW'(FIFO_DEPTH)) && (enable || (w_state_nxt != IDLE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_tpg        <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_s_ready    <= 1'b0;
      r_dpo        <= '0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
      r_sof_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_h_cnt      <= w_h_nxt;
      r_v_cnt      <= w_v_nxt;
      r_tpg        <= w_tpg_nxt;
      r_level      <= w_level_nxt;
      r_s_ready    <= w_ready_nxt;
      r_dpo        <= w_dpo_nxt;
      r_frame_done <= w_fd_nxt;
      if (w_push)   r_wr_ptr   <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr   <= r_rd_ptr + 1'b1;
      if (w_ur_set) r_underrun <= 1'b1;
      if (w_se_set) r_sof_err  <= 1'b1;
    end
  end

`ifdef NR_FRAMER_TPG_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [CW-1:0] r_bar_pix;
  logic [2:0]    r_bar_idx;

  assign w_tpg_sel = tpg_sel;

  // Bar position restarts at each line end, so bars stay aligned on every line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bar_pix <= '0;
      r_bar_idx <= '0;
    end else if (r_state == ACTIVE && r_tpg) begin
      if (r_h_cnt == CW'(H_ACTIVE - 1)) begin
        r_bar_pix <= '0;
        r_bar_idx <= '0;
      end else if (r_bar_pix == CW'(BAR_W - 1)) begin
        r_bar_pix <= '0;
        r_bar_idx <= r_bar_idx + 1'b1;
      end else begin
        r_bar_pix <= r_bar_pix + 1'b1;
      end
    end
  end

  always_comb begin
    w_bar_rgb = 24'h000000;
    case (r_bar_idx)
      3'd0:    w_bar_rgb = 24'hFFFFFF;
      3'd1:    w_bar_rgb = 24'hFFFF00;
      3'd2:    w_bar_rgb = 24'h00FFFF;
      3'd3:    w_bar_rgb = 24'h00FF00;
      3'd4:    w_bar_rgb = 24'hFF00FF;
      3'd5:    w_bar_rgb = 24'hFF0000;
      3'd6:    w_bar_rgb = 24'h0000FF;
      default: w_bar_rgb = 24'h000000;
    endcase
  end
`else
  assign w_tpg_sel = 1'b0;
  assign w_bar_rgb = 24'h000000;
`endif

  assign s_ready    = r_s_ready;
  assign dpo        = r_dpo;
  assign fifo_level = r_level;
  assign underrun   = r_underrun;
  assign sof_err    = r_sof_err;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_nr_raster_framer.sv
// Randomized self-checking bench for nr_raster_framer using a reduced raster.
module tb_nr_raster_framer;
  localparam int H = 32, V = 6, HB = 5, HS = 2, VG = 130, DEPTH = 64;
  localparam int NPIX = H * V;

  logic        clk, rst_n, enable, s_valid, s_ready, s_sof;
  logic [23:0] s_data;
  logic [26:0] dpo;
  logic [6:0]  fifo_level;
  logic        underrun, sof_err, frame_done;
`ifdef NR_FRAMER_TPG_EN
  logic        tpg_sel = 1'b0;
`endif

  nr_raster_framer #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .HSYNC_W(HS),
                     .V_GAP(VG), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sof(s_sof),
`ifdef NR_FRAMER_TPG_EN
    .tpg_sel(tpg_sel),
`endif
    .dpo(dpo), .fifo_level(fifo_level), .underrun(underrun), .sof_err(sof_err),
    .frame_done(frame_done));

  int checks = 0, failures = 0;
  int valid_pct = 100;
  logic [24:0] src_q[$], stim_q[$];
  logic [23:0] exp_q[$], q_pix[$];
  bit exp_err;
  int q_runs[$], q_gaps[$], q_hs[$], q_hsoff[$], q_vs[$], q_fd[$];
  int n_fd;
  int m_run, m_low, m_hs, m_hs_off, m_vs;
  bit m_gap_vs, m_seen;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Source: offers the head of src_q with probability valid_pct; retires it on handshake.
  initial begin
    bit fire;
    s_valid = 0; s_data = '0; s_sof = 0;
    forever begin
      @(negedge clk);
      fire = s_valid && s_ready;
      @(posedge clk); #1;
      if (fire && src_q.size() != 0) void'(src_q.pop_front());
      if (src_q.size() != 0 && int'($urandom_range(99)) < valid_pct) begin
        s_valid = 1;
        {s_sof, s_data} = src_q[0];
      end else begin
        s_valid = 0;
      end
    end
  end

  // Bus monitor: splits the raster into den runs, in-frame gaps, sync widths and frame_done position.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_run = 0; m_low = 0; m_hs = 0; m_hs_off = -1; m_vs = 0; m_gap_vs = 0; m_seen = 0;
    end else begin
      if (dpo[24]) begin
        if (m_run == 0 && m_seen && !m_gap_vs) begin
          q_gaps.push_back(m_low); q_hs.push_back(m_hs); q_hsoff.push_back(m_hs_off);
        end
        m_run++; q_pix.push_back(dpo[23:0]);
        m_low = 0; m_hs = 0; m_hs_off = -1; m_vs = 0; m_gap_vs = 0; m_seen = 1;
      end else begin
        if (m_run != 0) q_runs.push_back(m_run);
        m_run = 0; m_low++;
        if (dpo[25]) begin
          if (m_hs_off < 0) m_hs_off = m_low - 1;
          m_hs++;
        end
        if (dpo[26]) begin
          m_gap_vs = 1; m_vs++;
        end else if (m_vs != 0) begin
          q_vs.push_back(m_vs); m_vs = 0;
        end
      end
      if (frame_done) begin
        n_fd++; q_fd.push_back(m_low);
      end
    end
  end

  task automatic clear_mon();
    q_pix.delete(); q_runs.delete(); q_gaps.delete(); q_hs.delete(); q_hsoff.delete();
    q_vs.delete(); q_fd.delete(); n_fd = 0; stim_q.delete();
  endtask

  task automatic add_frame(input int garbage, input bit rnd, input int extra_sof);
    logic [23:0] d;
    for (int i = 0; i < garbage; i++) stim_q.push_back({1'b0, 24'($urandom)});
    for (int i = 0; i < NPIX; i++) begin
      d = rnd ? 24'($urandom) : 24'(i);
      stim_q.push_back({(i == 0) || (i == extra_sof), d});
    end
  endtask

  // Reference: skip to an sof entry, then the next H*V entries form one frame, output in order.
  task automatic start_stim();
    int pos;
    pos = 0; exp_q.delete(); exp_err = 0;
    foreach (stim_q[i]) begin
      if (pos == 0 && !stim_q[i][24]) continue;
      if (pos != 0 && stim_q[i][24]) exp_err = 1;
      exp_q.push_back(stim_q[i][23:0]);
      pos = (pos + 1) % NPIX;
    end
    foreach (stim_q[i]) src_q.push_back(stim_q[i]);
  endtask

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= q_pix.size() || q_pix[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic wait_frames(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 5000 * n; i++) begin
      @(posedge clk);
      if (n_fd >= n) begin ok = 1; break; end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; enable = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dpo, s_ready, underrun, sof_err, frame_done} !== '0 || fifo_level !== '0) begin
      failures++;
      $display("FAIL reset_state dpo=%h rdy=%b ur=%b se=%b fd=%b lvl=%0d required all 0",
               dpo, s_ready, underrun, sof_err, frame_done, fifo_level);
    end
    @(posedge clk); #1 rst_n = 1;
    repeat (5) @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || dpo !== '0) begin
      failures++; $display("FAIL idle_disabled rdy=%b dpo=%h required 0/0", s_ready, dpo);
    end
  endtask

  task automatic test_continuous();
    bit ok; int bad;
    clear_mon(); valid_pct = 100; enable = 1;
    add_frame(0, 0, -1); start_stim();
    wait_frames(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL cont_timeout frames=%0d required 1", n_fd); end
    checks++;
    if (q_pix.size() != NPIX || first_diff() != -1) begin
      failures++; $display("FAIL cont_pixels count=%0d first_bad=%0d required %0d/-1", q_pix.size(), first_diff(), NPIX);
    end
    checks++;
    if (q_pix.size() == 0 || q_pix[0] !== 24'h000000 || q_pix[q_pix.size()-1] !== 24'h0000BF) begin
      failures++; $display("FAIL cont_first_last got %h..%h required 000000..0000bf", q_pix[0], q_pix[$]);
    end
    bad = 0; foreach (q_runs[i]) if (q_runs[i] != H) bad++;
    checks++;
    if (q_runs.size() != V || bad != 0) begin
      failures++; $display("FAIL cont_runs runs=%0d bad=%0d required %0d/0", q_runs.size(), bad, V);
    end
    bad = 0; foreach (q_gaps[i]) if (q_gaps[i] != HB) bad++;
    checks++;
    if (q_gaps.size() != V - 1 || bad != 0) begin
      failures++; $display("FAIL cont_gaps gaps=%0d bad=%0d required %0d/0", q_gaps.size(), bad, V - 1);
    end
    bad = 0; foreach (q_hs[i]) if (q_hs[i] != HS || q_hsoff[i] != 0) bad++;
    checks++;
    if (q_hs.size() != V - 1 || bad != 0) begin
      failures++; $display("FAIL cont_hsync count=%0d bad=%0d required %0d/0", q_hs.size(), bad, V - 1);
    end
    checks++;
    if (n_fd != 1 || q_fd.size() != 1 || q_fd[0] != VG) begin
      failures++; $display("FAIL cont_frame_done pulses=%0d offset=%0d required 1/%0d", n_fd, q_fd[0], VG);
    end
    checks++;
    if (q_vs.size() != 1 || q_vs[0] != VG) begin
      failures++; $display("FAIL cont_vsync count=%0d width=%0d required 1/%0d", q_vs.size(), q_vs[0], VG);
    end
    checks++;
    if (underrun !== 1'b0 || sof_err !== 1'b0) begin
      failures++; $display("FAIL cont_flags ur=%b se=%b required 0/0", underrun, sof_err);
    end
  endtask

  task automatic test_garbage();
    bit ok;
    clear_mon(); add_frame(5, 1, -1); start_stim();
    wait_frames(1, ok);
    checks++;
    if (!ok || q_pix.size() != NPIX || first_diff() != -1) begin
      failures++; $display("FAIL garbage_pixels ok=%b count=%0d first_bad=%0d required 1/%0d/-1", ok, q_pix.size(), first_diff(), NPIX);
    end
    checks++;
    if (sof_err !== exp_err) begin
      failures++; $display("FAIL garbage_sof_err got %b required %b", sof_err, exp_err);
    end
  endtask

  task automatic test_bursty();
    bit ok; int bad;
    clear_mon(); valid_pct = 50; add_frame(0, 1, -1); start_stim();
    wait_frames(1, ok);
    valid_pct = 100;
    checks++;
    if (!ok || first_diff() != -1 || q_pix.size() != NPIX) begin
      failures++; $display("FAIL bursty_pixels ok=%b count=%0d first_bad=%0d required 1/%0d/-1", ok, q_pix.size(), first_diff(), NPIX);
    end
    bad = 0; foreach (q_runs[i]) if (q_runs[i] != H) bad++;
    foreach (q_gaps[i]) if (q_gaps[i] < HB) bad++;
    checks++;
    if (q_runs.size() != V || bad != 0) begin
      failures++; $display("FAIL bursty_lines runs=%0d bad=%0d required %0d/0", q_runs.size(), bad, V);
    end
    checks++;
    if (underrun !== 1'b0) begin
      failures++; $display("FAIL bursty_underrun got %b required 0", underrun);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_mon(); add_frame(0, 1, -1); add_frame(0, 1, -1); start_stim();
    wait_frames(2, ok);
    checks++;
    if (!ok || n_fd != 2 || q_runs.size() != 2 * V) begin
      failures++; $display("FAIL b2b_frames ok=%b frames=%0d runs=%0d required 1/2/%0d", ok, n_fd, q_runs.size(), 2 * V);
    end
    checks++;
    if (q_pix.size() != 2 * NPIX || first_diff() != -1) begin
      failures++; $display("FAIL b2b_pixels count=%0d first_bad=%0d required %0d/-1", q_pix.size(), first_diff(), 2 * NPIX);
    end
  endtask

  task automatic test_sof_err();
    bit ok;
    clear_mon(); add_frame(0, 1, int'($urandom_range(NPIX - 1, 1))); start_stim();
    wait_frames(1, ok);
    checks++;
    if (!ok || q_pix.size() != NPIX || first_diff() != -1) begin
      failures++; $display("FAIL soferr_pixels ok=%b count=%0d first_bad=%0d required 1/%0d/-1", ok, q_pix.size(), first_diff(), NPIX);
    end
    checks++;
    if (sof_err !== exp_err || exp_err !== 1'b1) begin
      failures++; $display("FAIL soferr_flag got %b required %b", sof_err, exp_err);
    end
  endtask

  task automatic test_disable();
    bit ok; int n;
    clear_mon(); add_frame(0, 1, -1); start_stim();
    for (n = 0; n < 5000 && q_pix.size() == 0; n++) @(posedge clk);
    enable = 0;
    wait_frames(1, ok);
    checks++;
    if (!ok || q_pix.size() != NPIX || first_diff() != -1) begin
      failures++; $display("FAIL disable_frame ok=%b count=%0d first_bad=%0d required 1/%0d/-1", ok, q_pix.size(), first_diff(), NPIX);
    end
    add_frame(0, 1, -1); foreach (stim_q[i]) src_q.push_back(stim_q[i]);
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b0 || fifo_level !== '0 || q_pix.size() != NPIX) begin
      failures++; $display("FAIL disable_idle rdy=%b lvl=%0d pix=%0d required 0/0/%0d", s_ready, fifo_level, q_pix.size(), NPIX);
    end
    src_q.delete();
  endtask

  task automatic test_reset_midline();
    int n;
    clear_mon(); enable = 1; add_frame(0, 1, -1); start_stim();
    for (n = 0; n < 5000 && q_pix.size() < 8; n++) @(negedge clk);
    @(posedge clk); #2 rst_n = 0;
    #1;
    checks++;
    if (dpo !== '0 || s_ready !== 1'b0 || q_pix.size() < 8) begin
      failures++; $display("FAIL reset_midline dpo=%h rdy=%b pix=%0d required 0/0/>=8", dpo, s_ready, q_pix.size());
    end
    enable = 0; src_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (fifo_level !== '0 || s_ready !== 1'b0 || dpo !== '0) begin
      failures++; $display("FAIL reset_release lvl=%0d rdy=%b dpo=%h required 0/0/0", fifo_level, s_ready, dpo);
    end
  endtask

  task automatic test_underrun();
    int n, bad;
    clear_mon(); enable = 1;
    stim_q.push_back({1'b1, 24'($urandom)});
    for (int i = 1; i < 24; i++) stim_q.push_back({1'b0, 24'($urandom)});
    foreach (stim_q[i]) src_q.push_back(stim_q[i]);
    for (n = 0; n < 2000 && fifo_level != 7'd24; n++) @(posedge clk);
    force dut.w_wait_ok = 1'b1;
    for (n = 0; n < 2000 && q_runs.size() == 0; n++) @(posedge clk);
    release dut.w_wait_ok;
    enable = 0;
    bad = 0;
    for (int i = 0; i < H; i++)
      if (i >= q_pix.size() || q_pix[i] !== ((i < 24) ? stim_q[i][23:0] : 24'h0)) bad++;
    checks++;
    if (q_runs.size() == 0 || q_runs[0] != H || bad != 0) begin
      failures++; $display("FAIL underrun_line run=%0d bad_pixels=%0d required %0d/0", q_runs[0], bad, H);
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (underrun !== 1'b1) begin
      failures++; $display("FAIL underrun_sticky got %b required 1", underrun);
    end
    rst_n = 0;
    #1;
    checks++;
    if (underrun !== 1'b0 || sof_err !== 1'b0) begin
      failures++; $display("FAIL underrun_clear ur=%b se=%b required 0/0", underrun, sof_err);
    end
    #20 rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_garbage();
    test_bursty();
    test_back_to_back();
    test_sof_err();
    test_disable();
    test_reset_midline();
    test_underrun();
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
